// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial packed-BCD adder/subtractor with start/busy/done handshake
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] a_r;
  logic [4*DIGITS-1:0] b_r;
  logic                sub_r;
  logic                carry;
  logic [CW-1:0]       count;

  logic [3:0] ad;
  logic [3:0] bd;
  logic [3:0] bp;
  logic [4:0] t;
  logic [4:0] t6;
  logic [3:0] dig;
  logic       carry_n;

  // True when any 4-bit digit of the operand is outside 0..9.
  function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Select the current digit pair and form one decimal digit plus carry.
  always_comb begin
    ad = 4'd0;
    bd = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (count == CW'(i)) begin
        ad = a_r[4*i +: 4];
        bd = b_r[4*i +: 4];
      end
    end
    // 9's complement of B; the initial carry of 1 makes it 10's complement.
    bp = sub_r ? (4'd9 - bd) : bd;
    t  = {1'b0, ad} + {1'b0, bp} + {4'd0, carry};
    t6 = t + 5'd6;
    if (t > 5'd9) begin
      dig     = t6[3:0];
      carry_n = 1'b1;
    end else begin
      dig     = t[3:0];
      carry_n = 1'b0;
    end
  end

  // Handshake FSM: latch operands on start, one digit per RUN cycle, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry   <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            carry   <= sub;
            count   <= '0;
            invalid <= has_bad(a) | has_bad(b);
            sum     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (count == CW'(i)) sum[4*i +: 4] <= dig;
          end
          carry <= carry_n;
          if (count == LAST) begin
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
            // Invalid operands still take the full run time, but report nothing.
            if (invalid) begin
              sum  <= '0;
              cout <= 1'b0;
            end else begin
              cout <= carry_n;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - scoreboard bench for bcd_serial_adder (DIGITS=4 and DIGITS=1)
module tb_bcd_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, sub4, start1, sub1;
  logic [15:0] a4, b4, sum4;
  logic [3:0]  a1, b1, sum1;
  logic        busy4, done4, cout4, inv4;
  logic        busy1, done1, cout1, inv1;

  exp_t q4[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .invalid(inv4)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .invalid(inv1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] v, input int d);
    int r;
    r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x, input int d);
    logic [15:0] r;
    int          y;
    r = '0;
    y = x;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic logic bad_bcd(input logic [15:0] v, input int d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Reference result from whole-number decimal arithmetic.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s, input int d);
    exp_t e;
    int   av, bv, m, r;
    m = pow10(d);
    if (bad_bcd(a, d) || bad_bcd(b, d)) begin
      e.sum = '0; e.cout = 1'b0; e.inv = 1'b1;
    end else begin
      av = bcd2int(a, d);
      bv = bcd2int(b, d);
      e.inv = 1'b0;
      if (s) begin
        r = av - bv;
        e.cout = (av >= bv);
        e.sum = int2bcd((r + m) % m, d);
      end else begin
        r = av + bv;
        e.cout = (r >= m);
        e.sum = int2bcd(r % m, d);
      end
    end
    return e;
  endfunction

  // Compare each done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) check("d4_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        check("d4_sum", 32'(sum4), 32'(e.sum));
        check("d4_cout", 32'(cout4), 32'(e.cout));
        check("d4_invalid", 32'(inv4), 32'(e.inv));
        check("d4_busy_at_done", 32'(busy4), 32'd0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) check("d1_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_sum", 32'(sum1), 32'(e.sum[3:0]));
        check("d1_cout", 32'(cout1), 32'(e.cout));
        check("d1_invalid", 32'(inv1), 32'(e.inv));
      end
    end
  end

  // One DIGITS=4 operation; cycle 0 is the cycle start is presented in.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic s, input logic hold);
    int cyc, busy_cnt;
    q4.push_back(model(a, b, s, 4));
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(negedge clk);
    cyc = 1;
    busy_cnt = 0;
    start4 = hold;
    a4 = 16'h9999; b4 = 16'h8888; sub4 = ~s;
    while (!done4 && cyc < 30) begin
      if (busy4) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0;
    check("d4_latency", 32'(cyc), 32'd5);
    check("d4_busy_cycles", 32'(busy_cnt), 32'd4);
    @(negedge clk);
    check("d4_done_pulse_width", 32'(done4), 32'd0);
    check("d4_idle_after_done", 32'(busy4), 32'd0);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic s);
    int cyc;
    q1.push_back(model({12'd0, a}, {12'd0, b}, s, 1));
    @(negedge clk);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(negedge clk);
    cyc = 1;
    start1 = 1'b0;
    a1 = 4'h0; b1 = 4'h0;
    while (!done1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("d1_latency", 32'(cyc), 32'd2);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy4), 32'd0);
    check("reset_done", 32'(done4), 32'd0);
    check("reset_sum", 32'(sum4), 32'd0);
    check("reset_cout", 32'(cout4), 32'd0);
    check("reset_invalid", 32'(inv4), 32'd0);
    start4 = 1'b0;
    reset = 1'b0;

    run4(16'h9999, 16'h0001, 1'b0, 1'b0);
    run4(16'h1234, 16'h5678, 1'b0, 1'b0);
    run4(16'h0009, 16'h0009, 1'b0, 1'b0);
    run4(16'h0500, 16'h0123, 1'b1, 1'b0);
    run4(16'h0123, 16'h0500, 1'b1, 1'b0);
    run4(16'h0000, 16'h0000, 1'b1, 1'b0);
    run4(16'h00A1, 16'h0001, 1'b0, 1'b0);
    run4(16'h0001, 16'h0001, 1'b0, 1'b0);
    run4(16'h4321, 16'h1111, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] ra, rb;
      ra = int2bcd(int'($urandom_range(0, 9999)), 4);
      rb = int2bcd(int'($urandom_range(0, 9999)), 4);
      run4(ra, rb, 1'(k), 1'b0);
    end

    // Abort: leave cout=1 from a carry op, start an invalid op, reset mid-run.
    run4(16'h9999, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    a4 = 16'h00A1; b4 = 16'h0001; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_sum", 32'(sum4), 32'd0);
    check("abort_cout", 32'(cout4), 32'd0);
    check("abort_invalid", 32'(inv4), 32'd0);
    repeat (8) @(negedge clk);
    run4(16'h2468, 16'h1357, 1'b0, 1'b0);

    run1(4'h9, 4'h9, 1'b0);
    run1(4'h3, 4'h7, 1'b1);
    run1(4'hC, 4'h1, 1'b0);

    repeat (3) @(negedge clk);
    check("d4_queue_drained", 32'(q4.size()), 32'd0);
    check("d1_queue_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
